// File: rtl/game_pkg.sv
// Shared types and constants for the game controller.
// game_state_t fixes the state encoding seen by the bird, pipe and score logic.
package game_pkg;

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_ACTIVE    = 3'd2,
        ST_DYING     = 3'd3,
        ST_PAUSED    = 3'd4,
        ST_OVER      = 3'd5
    } game_state_t;

    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_P     = 8'h13;

    // Width of the shared frame counter: it must hold max(a,b)-1.
    // The result is never allowed to fall below one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Single-key press detector: pulses for one Clk when keycode first equals KEY.
// A key that stays held does not produce a second pulse.
module key_edge_detect #(
    parameter logic [7:0] KEY = 8'h00
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    output logic       press
);

    logic [7:0] key_prev;

    // Keep last cycle's keycode so that only a change onto KEY counts as a press.
    always_ff @(posedge Clk) begin
        // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
        if (Reset) begin
            key_prev <= 8'h00;
        end else begin
            key_prev <= keycode;
        end
    end

    assign press = (keycode == KEY) && (key_prev != KEY);

endmodule

// File: rtl/game_ctrl_fsm.sv
// Top-level game controller: lives, get-ready countdown, death hold, game over.
// Define GAME_FSM_PAUSE_EN to enable the PAUSED state (toggled by PAUSE_KEY).
// Without it, PAUSE_KEY is ignored and the PAUSED encoding is treated as illegal.
module game_ctrl_fsm
    import game_pkg::*;
#(
    parameter int          LIVES            = 3,
    parameter int          COUNTDOWN_FRAMES = 120,
    parameter int          DEATH_FRAMES     = 60,
    parameter logic [7:0]  START_KEY        = KEY_SPACE,
    parameter logic [7:0]  RESTART_KEY      = KEY_ENTER,
    parameter logic [7:0]  PAUSE_KEY        = KEY_P,
    localparam int         LW               = $clog2(LIVES + 1),
    localparam int         CW               = cnt_width(COUNTDOWN_FRAMES, DEATH_FRAMES)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          frame_tick,
    input  logic [7:0]    keycode,
    input  logic          collision,
    input  logic          is_bottom,
    output game_state_t   game_state,
    output logic [LW-1:0] lives_left,
    output logic [CW-1:0] countdown,
    output logic          freeze,
    output logic          new_game,
    output logic          life_lost
);

    localparam logic [LW-1:0] LIVES_INIT = LW'(LIVES);
    localparam logic [LW-1:0] LIVES_ONE  = LW'(1);
    localparam logic [CW-1:0] CD_LOAD    = CW'(COUNTDOWN_FRAMES - 1);
    localparam logic [CW-1:0] DEATH_LOAD = CW'(DEATH_FRAMES - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    logic          start_press;
    logic          restart_press;
    logic          hit;

    game_state_t   state_d;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;
    logic [LW-1:0] lives_d;
    logic          new_game_d;
    logic          life_lost_d;

    key_edge_detect #(.KEY(START_KEY)) u_start_key (
        .Clk     (Clk),
        .Reset   (Reset),
        .keycode (keycode),
        .press   (start_press)
    );

    key_edge_detect #(.KEY(RESTART_KEY)) u_restart_key (
        .Clk     (Clk),
        .Reset   (Reset),
        .keycode (keycode),
        .press   (restart_press)
    );

`ifdef GAME_FSM_PAUSE_EN
    logic pause_press;

    key_edge_detect #(.KEY(PAUSE_KEY)) u_pause_key (
        .Clk     (Clk),
        .Reset   (Reset),
        .keycode (keycode),
        .press   (pause_press)
    );
`else
    // PAUSE_KEY has no function in this build.
    logic unused_pause_key;
    assign unused_pause_key = ^PAUSE_KEY;
`endif

    assign hit = collision | is_bottom;

    // Next-state, counter, lives and pulse decisions for the current state.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
        state_d     = game_state;
        cnt_d       = cnt;
        lives_d     = lives_left;
        new_game_d  = 1'b0;
        life_lost_d = 1'b0;

        case (game_state)
            ST_START: begin
                if (start_press) begin
                    state_d    = ST_COUNTDOWN;
                    lives_d    = LIVES_INIT;
                    cnt_d      = CD_LOAD;
                    new_game_d = 1'b1;
                end
            end

            ST_COUNTDOWN: begin
                if (frame_tick) begin
                    if (cnt == '0) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        cnt_d = cnt - CNT_ONE;
                    end
                end
            end

            ST_ACTIVE: begin
                // A hit wins over a pause request in the same cycle.
                if (hit) begin
                    state_d     = ST_DYING;
                    lives_d     = (lives_left == '0) ? '0 : lives_left - LIVES_ONE;
                    cnt_d       = DEATH_LOAD;
                    life_lost_d = 1'b1;
                end
`ifdef GAME_FSM_PAUSE_EN
                else if (pause_press) begin
                    state_d = ST_PAUSED;
                end
`endif
            end

            ST_DYING: begin
                if (frame_tick) begin
                    if (cnt == '0) begin
                        if (lives_left == '0) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d = ST_COUNTDOWN;
                            cnt_d   = CD_LOAD;
                        end
                    end else begin
                        cnt_d = cnt - CNT_ONE;
                    end
                end
            end

`ifdef GAME_FSM_PAUSE_EN
            ST_PAUSED: begin
                if (pause_press) begin
                    state_d = ST_ACTIVE;
                end else if (restart_press) begin
                    state_d = ST_START;
                end
            end
`endif

            ST_OVER: begin
                if (restart_press) begin
                    state_d = ST_START;
                end
            end

            default: begin
                state_d = ST_START;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counters and all outputs are registered together.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            game_state <= ST_START;
            lives_left <= LIVES_INIT;
            cnt        <= '0;
            countdown  <= '0;
            freeze     <= 1'b1;
            new_game   <= 1'b0;
            life_lost  <= 1'b0;
        end else begin
            game_state <= state_d;
            lives_left <= lives_d;
            cnt        <= cnt_d;
            countdown  <= (state_d == ST_COUNTDOWN) ? cnt_d : '0;
            freeze     <= (state_d != ST_ACTIVE);
            new_game   <= new_game_d;
            life_lost  <= life_lost_d;
        end
    end

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Self-checking bench for game_ctrl_fsm with LIVES=2, COUNTDOWN_FRAMES=3, DEATH_FRAMES=2.
// Honours GAME_FSM_PAUSE_EN the same way the design does.
module tb_game_ctrl_fsm;

    localparam int LIVES = 2;
    localparam int CF    = 3;
    localparam int DF    = 2;
    localparam int LW    = 2;
    localparam int CW    = 2;

    localparam logic [7:0] K_START   = 8'h2C;
    localparam logic [7:0] K_RESTART = 8'h28;
    localparam logic [7:0] K_PAUSE   = 8'h13;

    localparam int S_START     = 0;
    localparam int S_COUNTDOWN = 1;
    localparam int S_ACTIVE    = 2;
    localparam int S_DYING     = 3;
    localparam int S_PAUSED    = 4;
    localparam int S_OVER      = 5;

`ifdef GAME_FSM_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic          Clk;
    logic          Reset;
    logic          frame_tick;
    logic [7:0]    keycode;
    logic          collision;
    logic          is_bottom;
    logic [2:0]    game_state;
    logic [LW-1:0] lives_left;
    logic [CW-1:0] countdown;
    logic          freeze;
    logic          new_game;
    logic          life_lost;

    int errors = 0;
    int checks = 0;

    game_ctrl_fsm #(
        .LIVES            (LIVES),
        .COUNTDOWN_FRAMES (CF),
        .DEATH_FRAMES     (DF),
        .START_KEY        (K_START),
        .RESTART_KEY      (K_RESTART),
        .PAUSE_KEY        (K_PAUSE)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .keycode    (keycode),
        .collision  (collision),
        .is_bottom  (is_bottom),
        .game_state (game_state),
        .lives_left (lives_left),
        .countdown  (countdown),
        .freeze     (freeze),
        .new_game   (new_game),
        .life_lost  (life_lost)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Tracks the game as "ticks still to wait" rather than a down-counter value.
    int         m_state;
    int         m_lives;
    int         m_remain;
    logic [7:0] m_prev;
    bit         m_new;
    bit         m_lost;

    function automatic bit pressed(input logic [7:0] kc, input logic [7:0] k);
        return (kc == k) && (m_prev != k);
    endfunction

    task automatic model_clock(input bit rst, input bit tick, input logic [7:0] kc,
                               input bit col, input bit bot);
        bit hit;
        hit    = col | bot;
        m_new  = 1'b0;
        m_lost = 1'b0;
        if (rst) begin
            m_state  = S_START;
            m_lives  = LIVES;
            m_remain = 0;
            m_prev   = 8'h00;
        end else begin
            case (m_state)
                S_START: if (pressed(kc, K_START)) begin
                    m_state  = S_COUNTDOWN;
                    m_lives  = LIVES;
                    m_remain = CF;
                    m_new    = 1'b1;
                end
                S_COUNTDOWN: if (tick) begin
                    m_remain--;
                    if (m_remain == 0) m_state = S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (hit) begin
                        m_state  = S_DYING;
                        m_lives  = (m_lives > 0) ? m_lives - 1 : 0;
                        m_remain = DF;
                        m_lost   = 1'b1;
                    end else if (PAUSE_EN && pressed(kc, K_PAUSE)) begin
                        m_state = S_PAUSED;
                    end
                end
                S_DYING: if (tick) begin
                    m_remain--;
                    if (m_remain == 0) begin
                        if (m_lives == 0) begin
                            m_state = S_OVER;
                        end else begin
                            m_state  = S_COUNTDOWN;
                            m_remain = CF;
                        end
                    end
                end
                S_PAUSED: begin
                    if (pressed(kc, K_PAUSE)) m_state = S_ACTIVE;
                    else if (pressed(kc, K_RESTART)) m_state = S_START;
                end
                S_OVER: if (pressed(kc, K_RESTART)) m_state = S_START;
                default: m_state = S_START;
            endcase
            m_prev = kc;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".state"},     32'(game_state), m_state);
        check({tag, ".lives"},     32'(lives_left), m_lives);
        check({tag, ".countdown"}, 32'(countdown),  (m_state == S_COUNTDOWN) ? m_remain - 1 : 0);
        check({tag, ".freeze"},    32'(freeze),     32'(m_state != S_ACTIVE));
        check({tag, ".new_game"},  32'(new_game),   32'(m_new));
        check({tag, ".life_lost"}, 32'(life_lost),  32'(m_lost));
    endtask

    // Drive one cycle of inputs at the falling edge; outputs are stable 1 time unit after the rising edge.
    task automatic step(input bit rst, input bit tick, input logic [7:0] kc, input bit col, input bit bot);
        @(negedge Clk);
        Reset      = rst;
        frame_tick = tick;
        keycode    = kc;
        collision  = col;
        is_bottom  = bot;
        @(posedge Clk);
        model_clock(rst, tick, kc, col, bot);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         rst;
        bit         tick;
        logic [7:0] kc;
        bit         col;
        bit         bot;
        int         st;
        int         lv;
        int         cd;
        bit         fr;
        bit         ng;
        bit         ll;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit rst, input bit tick, input logic [7:0] kc, input bit col,
                                input bit bot, input int st, input int lv, input int cd,
                                input bit fr, input bit ng, input bit ll);
        vec_t v;
        v.rst = rst; v.tick = tick; v.kc = kc; v.col = col; v.bot = bot;
        v.st = st; v.lv = lv; v.cd = cd; v.fr = fr; v.ng = ng; v.ll = ll;
        return v;
    endfunction

    initial begin
        int         pulses;
        int         seq[$];
        int         last_cd;
        logic [7:0] kc_r;
        string      tag;

        Reset = 1'b1; frame_tick = 1'b0; keycode = 8'h00; collision = 1'b0; is_bottom = 1'b0;
        model_clock(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        //              rst tick kc     col bot  st lv cd fr ng ll
        vecs.push_back(mk(1, 0, 8'h00, 0, 0,   0, 2, 0, 1, 0, 0)); // reset
        vecs.push_back(mk(0, 0, 8'h2C, 0, 0,   1, 2, 2, 1, 1, 0)); // start press
        vecs.push_back(mk(0, 0, 8'h2C, 0, 0,   1, 2, 2, 1, 0, 0)); // held: no retrigger
        vecs.push_back(mk(0, 1, 8'h2C, 1, 0,   1, 2, 1, 1, 0, 0)); // collision ignored
        vecs.push_back(mk(0, 1, 8'h00, 0, 0,   1, 2, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1,   1, 2, 0, 1, 0, 0)); // floor ignored
        vecs.push_back(mk(0, 1, 8'h00, 0, 0,   2, 2, 0, 0, 0, 0)); // ACTIVE
        vecs.push_back(mk(0, 0, 8'h2C, 0, 0,   2, 2, 0, 0, 0, 0)); // start key ignored
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,   3, 1, 0, 1, 0, 1)); // hit
        vecs.push_back(mk(0, 1, 8'h00, 1, 0,   3, 1, 0, 1, 0, 0)); // hit in DYING ignored
        vecs.push_back(mk(0, 1, 8'h00, 0, 0,   1, 1, 2, 1, 0, 0)); // back to COUNTDOWN
        vecs.push_back(mk(0, 1, 8'h00, 0, 0,   1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 0,   1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 0,   2, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1,   3, 0, 0, 1, 0, 1)); // last life lost
        vecs.push_back(mk(0, 1, 8'h00, 0, 0,   3, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 0,   5, 0, 0, 1, 0, 0)); // OVER
        vecs.push_back(mk(0, 0, 8'h2C, 1, 0,   5, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h28, 0, 0,   0, 0, 0, 1, 0, 0)); // restart -> START
        vecs.push_back(mk(0, 1, 8'h28, 0, 0,   0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h2C, 0, 0,   1, 2, 2, 1, 1, 0)); // lives restored

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].tick, vecs[i].kc, vecs[i].col, vecs[i].bot);
            tag = $sformatf("vec%0d", i);
            check({tag, ".state"},     32'(game_state), vecs[i].st);
            check({tag, ".lives"},     32'(lives_left), vecs[i].lv);
            check({tag, ".countdown"}, 32'(countdown),  vecs[i].cd);
            check({tag, ".freeze"},    32'(freeze),     32'(vecs[i].fr));
            check({tag, ".new_game"},  32'(new_game),   32'(vecs[i].ng));
            check({tag, ".life_lost"}, 32'(life_lost),  32'(vecs[i].ll));
        end

        // ---- start key held 20 Clk, frame tick every 4 Clk ----
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_model("hold.reset");
        pulses  = 0;
        last_cd = -1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, (i % 4) == 3, K_START, 1'b0, 1'b0);
            check_model($sformatf("hold%0d", i));
            if (new_game) pulses++;
            if (game_state == 3'(S_COUNTDOWN) && int'(countdown) != last_cd) begin
                seq.push_back(int'(countdown));
                last_cd = int'(countdown);
            end
        end
        check("hold.new_game_pulses", pulses, 1);
        check("hold.cd_values", seq.size(), 3);
        if (seq.size() == 3) begin
            check("hold.cd0", seq[0], 2);
            check("hold.cd1", seq[1], 1);
            check("hold.cd2", seq[2], 0);
        end
        check("hold.final_state", 32'(game_state), S_ACTIVE);

        // ---- pause key handling (both builds) ----
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_model("pause.release");
        step(1'b0, 1'b0, K_PAUSE, 1'b0, 1'b0);
        check_model("pause.press");
        check("pause.press_state", 32'(game_state), PAUSE_EN ? S_PAUSED : S_ACTIVE);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, K_PAUSE, PAUSE_EN, 1'b0);
            check_model($sformatf("pause.hold%0d", i));
        end
        check("pause.hold_state", 32'(game_state), PAUSE_EN ? S_PAUSED : S_ACTIVE);
        check("pause.hold_lives", 32'(lives_left), 2);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, K_PAUSE, 1'b0, 1'b0);
        check_model("pause.resume");
        check("pause.resume_state", 32'(game_state), S_ACTIVE);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, K_PAUSE, 1'b1, 1'b0);
        check_model("pause.hit_wins");
        check("pause.hit_state", 32'(game_state), S_DYING);
        check("pause.hit_pulse", 32'(life_lost), 1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            check_model($sformatf("pause.recover%0d", i));
        end
        check("pause.recover_state", 32'(game_state), S_ACTIVE);
        step(1'b0, 1'b0, K_PAUSE, 1'b0, 1'b0);
        check_model("pause.again");
        step(1'b0, 1'b0, K_RESTART, 1'b0, 1'b0);
        check_model("pause.restart");
        check("pause.restart_state", 32'(game_state), PAUSE_EN ? S_START : S_ACTIVE);

        // ---- reset pulse while DYING with one life left ----
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, K_START, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("rst.pre_state", 32'(game_state), S_DYING);
        check("rst.pre_lives", 32'(lives_left), 1);
        step(1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
        check("rst.state", 32'(game_state), S_START);
        check("rst.lives", 32'(lives_left), 2);
        check("rst.countdown", 32'(countdown), 0);
        check("rst.freeze", 32'(freeze), 1);
        check("rst.new_game", 32'(new_game), 0);
        check("rst.life_lost", 32'(life_lost), 0);
        check_model("rst.model");

        // ---- randomized stimulus against the reference model ----
        kc_r = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 7))
                    4:       kc_r = K_START;
                    5:       kc_r = K_RESTART;
                    6:       kc_r = K_PAUSE;
                    7:       kc_r = 8'($urandom_range(1, 255));
                    default: kc_r = 8'h00;
                endcase
            end
            step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, kc_r,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);
            check_model($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
